// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD result display: FSM states, HD44780
// command bytes, ASCII constants and small helpers used by the sequencer and byte writer.
package lcd_pkg;

   typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, WRITE} state_t;
   typedef enum logic [1:0] {BW_IDLE, BW_SETUP, BW_EN, BW_HOLD} bw_phase_t;
   typedef enum logic {WAIT_CMD, WAIT_CLEAR} byte_wait_t;

   localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
   localparam logic [7:0] DISP_ON       = 8'h0C;
   localparam logic [7:0] ENTRY_INC     = 8'h06;
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] LINE1_HOME    = 8'h80;

   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_C  = 8'h43;
   localparam logic [7:0] ASCII_EQ = 8'h3D;
   localparam logic [7:0] ASCII_0  = 8'h30;

   localparam logic [3:0] INIT_LEN  = 4'd4;
   localparam logic [3:0] WRITE_LEN = 4'd8;

   typedef struct packed {
      logic [3:0] hun;
      logic [3:0] ten;
      logic [3:0] one;
   } bcd_t;

   function automatic bcd_t to_bcd(input logic [7:0] v);
      bcd_t b;
      b.hun = 4'(v / 8'd100);
      b.ten = 4'((v % 8'd100) / 8'd10);
      b.one = 4'(v % 8'd10);
      return b;
   endfunction

   // Only clear-display needs the long post-strobe wait.
   function automatic byte_wait_t byte_wait_sel(input logic rs, input logic [7:0] d);
      return (!rs && d == CLEAR) ? WAIT_CLEAR : WAIT_CMD;
   endfunction

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = FUNC_SET_8B2L;
         2'd1:    b = DISP_ON;
         2'd2:    b = ENTRY_INC;
         default: b = CLEAR;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus transfer: setup cycle, enable pulse, then post-strobe hold/wait.
// ready is high when idle or in the last wait cycle so bytes can run back to back.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int ENABLE_CYC = 25,
   parameter int CMD_CYC    = 2000,
   parameter int CLEAR_CYC  = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       ready,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       lcd_e
);

   localparam int MAX_CYC = (CLEAR_CYC > CMD_CYC) ?
                            ((CLEAR_CYC > ENABLE_CYC) ? CLEAR_CYC : ENABLE_CYC) :
                            ((CMD_CYC > ENABLE_CYC) ? CMD_CYC : ENABLE_CYC);
   localparam int CW = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0] EN_LD  = CW'(ENABLE_CYC - 1);
   localparam logic [CW-1:0] CMD_LD = CW'(CMD_CYC - 1);
   localparam logic [CW-1:0] CLR_LD = CW'(CLEAR_CYC - 1);

   bw_phase_t      phase, phase_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           e_n;
   logic           load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= BW_IDLE;
         cnt      <= '0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
      end else begin
         phase <= phase_n;
         cnt   <= cnt_n;
         lcd_e <= e_n;
         if (load) begin
            lcd_rs   <= rs;
            lcd_data <= data;
         end
      end
   end

   // Bus lines only load in BW_IDLE/BW_HOLD, so they are frozen while lcd_e is high.
   always_comb begin
      phase_n = phase;
      cnt_n   = cnt;
      e_n     = lcd_e;
      load    = 1'b0;
      ready   = 1'b0;
      case (phase)
         BW_IDLE: begin
            ready = 1'b1;
            if (start) begin
               load    = 1'b1;
               phase_n = BW_SETUP;
            end
         end
         BW_SETUP: begin
            e_n     = 1'b1;
            cnt_n   = EN_LD;
            phase_n = BW_EN;
         end
         BW_EN: begin
            if (cnt == '0) begin
               e_n     = 1'b0;
               phase_n = BW_HOLD;
               cnt_n   = (byte_wait_sel(lcd_rs, lcd_data) == WAIT_CLEAR) ? CLR_LD : CMD_LD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            if (cnt == '0) begin
               ready = 1'b1;
               if (start) begin
                  load    = 1'b1;
                  phase_n = BW_SETUP;
               end else begin
                  phase_n = BW_IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/lcd_result_display.sv
// Captures the core accumulator on each data_ready rise and shows "ACC=ddd" on
// LCD line 1; owns power-up wait, controller init and byte sequencing.
//
// state    | meaning
// PWR_WAIT | post-reset power-up delay before any bus activity
// INIT     | sending function set, display on, entry mode, clear
// IDLE     | waiting for a captured result (busy=0)
// WRITE    | sending line-1 home, "ACC=" and three digits
module lcd_result_display
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC  = 750000,
   parameter int ENABLE_CYC = 25,
   parameter int CMD_CYC    = 2000,
   parameter int CLEAR_CYC  = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_ready,
   input  logic [7:0] accumulator,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       busy
);

   localparam int PW = $clog2(PWRUP_CYC) + 1;
   localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);

   state_t         state, state_n;
   logic [PW-1:0]  counter, counter_n;
   logic [3:0]     idx, idx_n;
   logic           dr_q, rise, pending, take;
   logic [7:0]     value_q;
   bcd_t           digits;
   logic           bw_start, bw_rs, bw_ready;
   logic [7:0]     bw_data;

   assign rise   = data_ready & ~dr_q;
   assign busy   = (state != IDLE);
   assign lcd_rw = 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= PWR_WAIT;
         counter <= '0;
         idx     <= '0;
         dr_q    <= 1'b0;
         pending <= 1'b0;
         value_q <= 8'h00;
         digits  <= '0;
      end else begin
         state   <= state_n;
         counter <= counter_n;
         idx     <= idx_n;
         dr_q    <= data_ready;
         if (rise) begin
            value_q <= accumulator;
            pending <= 1'b1;
         end else if (take) begin
            pending <= 1'b0;
         end
         if (take) digits <= to_bcd(value_q);
      end
   end

   always_comb begin
      state_n   = state;
      counter_n = counter;
      idx_n     = idx;
      take      = 1'b0;
      bw_start  = 1'b0;
      bw_rs     = 1'b0;
      bw_data   = 8'h00;
      case (state)
         PWR_WAIT: begin
            if (counter == PWR_LAST) begin
               counter_n = '0;
               state_n   = INIT;
            end else begin
               counter_n = counter + 1'b1;
            end
         end
         INIT: begin
            if (bw_ready) begin
               if (idx == INIT_LEN) begin
                  idx_n   = '0;
                  state_n = IDLE;
               end else begin
                  bw_start = 1'b1;
                  bw_data  = init_byte(idx[1:0]);
                  idx_n    = idx + 1'b1;
               end
            end
         end
         IDLE: begin
            if (pending) begin
               take    = 1'b1;
               state_n = WRITE;
            end
         end
         default: begin
            if (bw_ready) begin
               if (idx == WRITE_LEN) begin
                  idx_n   = '0;
                  state_n = IDLE;
               end else begin
                  bw_start = 1'b1;
                  bw_rs    = (idx != 4'd0);
                  idx_n    = idx + 1'b1;
                  case (idx)
                     4'd0:    bw_data = LINE1_HOME;
                     4'd1:    bw_data = ASCII_A;
                     4'd2:    bw_data = ASCII_C;
                     4'd3:    bw_data = ASCII_C;
                     4'd4:    bw_data = ASCII_EQ;
                     4'd5:    bw_data = ASCII_0 + {4'h0, digits.hun};
                     4'd6:    bw_data = ASCII_0 + {4'h0, digits.ten};
                     default: bw_data = ASCII_0 + {4'h0, digits.one};
                  endcase
               end
            end
         end
      endcase
   end

   lcd_byte_writer #(
      .ENABLE_CYC (ENABLE_CYC),
      .CMD_CYC    (CMD_CYC),
      .CLEAR_CYC  (CLEAR_CYC)
   ) u_byte_writer (
      .clk      (clk),
      .reset    (reset),
      .start    (bw_start),
      .rs       (bw_rs),
      .data     (bw_data),
      .ready    (bw_ready),
      .lcd_rs   (lcd_rs),
      .lcd_data (lcd_data),
      .lcd_e    (lcd_e)
   );

endmodule

// File: tb/tb_lcd_result_display.sv
// Scoreboard bench for lcd_result_display: expected LCD bytes are queued as
// stimulus is applied and popped on every lcd_e rising edge.
module tb_lcd_result_display;

   localparam int PWRUP_CYC  = 10;
   localparam int ENABLE_CYC = 2;
   localparam int CMD_CYC    = 4;
   localparam int CLEAR_CYC  = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       data_ready = 1'b0;
   logic [7:0] accumulator = 8'h00;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_e, busy;

   lcd_result_display #(
      .PWRUP_CYC  (PWRUP_CYC),
      .ENABLE_CYC (ENABLE_CYC),
      .CMD_CYC    (CMD_CYC),
      .CLEAR_CYC  (CLEAR_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_ready  (data_ready),
      .accumulator (accumulator),
      .lcd_data    (lcd_data),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       last;
      logic       rs;
      logic [7:0] data;
   } sb_t;

   sb_t sb[$];
   int  n_vec  = 0;
   int  n_miss = 0;
   int  bytes_seen = 0;

   // Monitor state
   logic       e_prev = 1'b0;
   logic       have_prev = 1'b0;
   logic       prev_last = 1'b0;
   int         prev_gap = 0;
   int         low_run = 0;
   int         high_run = 0;
   logic       cur_rs;
   logic [7:0] cur_data;

   always @(negedge clk) begin
      if (!reset) begin
         e_prev    = 1'b0;
         have_prev = 1'b0;
         low_run   = 0;
         high_run  = 0;
      end else begin
         n_vec++;
         if (lcd_rw !== 1'b0) begin
            n_miss++;
            $display("FAIL lcd_rw: got %b want 0", lcd_rw);
         end
         if (lcd_e === 1'b1 && !e_prev) begin
            bytes_seen++;
            n_vec++;
            if (busy !== 1'b1) begin
               n_miss++;
               $display("FAIL busy_during_byte: got %b want 1", busy);
            end
            n_vec++;
            if (sb.size() == 0) begin
               n_miss++;
               $display("FAIL unexpected_byte: got rs=%b data=%h want no byte", lcd_rs, lcd_data);
            end else begin
               sb_t e;
               e = sb.pop_front();
               if (lcd_rs !== e.rs || lcd_data !== e.data) begin
                  n_miss++;
                  $display("FAIL byte_value: got rs=%b data=%h want rs=%b data=%h",
                           lcd_rs, lcd_data, e.rs, e.data);
               end
               if (have_prev && !prev_last) begin
                  n_vec++;
                  if (low_run != prev_gap) begin
                     n_miss++;
                     $display("FAIL byte_gap: got %0d low cycles want %0d", low_run, prev_gap);
                  end
               end
               prev_last = e.last;
               prev_gap  = ((!e.rs && e.data == 8'h01) ? CLEAR_CYC : CMD_CYC) + 1;
               have_prev = 1'b1;
            end
            cur_rs   = lcd_rs;
            cur_data = lcd_data;
            high_run = 1;
         end else if (lcd_e === 1'b1) begin
            n_vec++;
            if (lcd_rs !== cur_rs || lcd_data !== cur_data) begin
               n_miss++;
               $display("FAIL bus_stable: got rs=%b data=%h want rs=%b data=%h",
                        lcd_rs, lcd_data, cur_rs, cur_data);
            end
            high_run++;
         end else if (e_prev) begin
            n_vec++;
            if (high_run != ENABLE_CYC) begin
               n_miss++;
               $display("FAIL e_width: got %0d want %0d", high_run, ENABLE_CYC);
            end
            low_run = 1;
         end else begin
            low_run++;
         end
         e_prev = lcd_e;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_init();
      sb.push_back('{1'b0, 1'b0, 8'h38});
      sb.push_back('{1'b0, 1'b0, 8'h0C});
      sb.push_back('{1'b0, 1'b0, 8'h06});
      sb.push_back('{1'b1, 1'b0, 8'h01});
   endtask

   task automatic push_write(input logic [7:0] v);
      int h, t, o;
      h = int'(v) / 100;
      t = (int'(v) / 10) % 10;
      o = int'(v) % 10;
      sb.push_back('{1'b0, 1'b0, 8'h80});
      sb.push_back('{1'b0, 1'b1, 8'h41});
      sb.push_back('{1'b0, 1'b1, 8'h43});
      sb.push_back('{1'b0, 1'b1, 8'h43});
      sb.push_back('{1'b0, 1'b1, 8'h3D});
      sb.push_back('{1'b0, 1'b1, 8'(8'h30 + h)});
      sb.push_back('{1'b0, 1'b1, 8'(8'h30 + t)});
      sb.push_back('{1'b1, 1'b1, 8'(8'h30 + o)});
   endtask

   task automatic raise_dr(input logic [7:0] v, input bit expect_write);
      accumulator = v;
      data_ready  = 1'b1;
      if (expect_write) push_write(v);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      n_vec++;
      if (n >= budget) begin
         n_miss++;
         $display("FAIL %s_timeout: busy=%b queued=%0d after %0d cycles, want idle", name, busy, sb.size(), n);
      end
   endtask

   task automatic wait_bytes(input string name, input int target, input int budget);
      int n = 0;
      while (bytes_seen < target && n < budget) begin
         tick();
         n++;
      end
      n_vec++;
      if (n >= budget) begin
         n_miss++;
         $display("FAIL %s_timeout: bytes=%0d want %0d", name, bytes_seen, target);
      end
   endtask

   task automatic test_reset();
      int n, base;
      reset = 1'b0;
      data_ready = 1'b0;
      repeat (3) tick();
      n_vec += 5;
      if (lcd_e !== 1'b0)     begin n_miss++; $display("FAIL rst_e: got %b want 0", lcd_e); end
      if (lcd_rs !== 1'b0)    begin n_miss++; $display("FAIL rst_rs: got %b want 0", lcd_rs); end
      if (lcd_data !== 8'h00) begin n_miss++; $display("FAIL rst_data: got %h want 00", lcd_data); end
      if (lcd_rw !== 1'b0)    begin n_miss++; $display("FAIL rst_rw: got %b want 0", lcd_rw); end
      if (busy !== 1'b1)      begin n_miss++; $display("FAIL rst_busy: got %b want 1", busy); end
      base = bytes_seen;
      reset = 1'b1;
      push_init();
      n = 0;
      while (lcd_e !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_vec++;
      if (n < PWRUP_CYC + 1 || n > PWRUP_CYC + 3) begin
         n_miss++;
         $display("FAIL pwrup_delay: first lcd_e after %0d cycles want %0d..%0d", n, PWRUP_CYC + 1, PWRUP_CYC + 3);
      end
      wait_bytes("init", base + 4, 200);
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      n_vec++;
      if (n != ENABLE_CYC + CLEAR_CYC) begin
         n_miss++;
         $display("FAIL busy_fall: got %0d cycles after clear strobe want %0d", n, ENABLE_CYC + CLEAR_CYC);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL init_bytes: got %0d left want 0", sb.size());
      end
   endtask

   task automatic test_write_ff();
      int lat, base;
      base = bytes_seen;
      raise_dr(8'hFF, 1);
      lat = 0;
      while (lcd_e !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_vec += 2;
      if (lat > 4) begin
         n_miss++;
         $display("FAIL latency: got %0d cycles want <=4", lat);
      end
      if (busy !== 1'b1) begin
         n_miss++;
         $display("FAIL write_busy: got %b want 1", busy);
      end
      data_ready = 1'b0;
      wait_idle("write_ff", 200);
      n_vec++;
      if (bytes_seen - base != 8) begin
         n_miss++;
         $display("FAIL write_ff_count: got %0d bytes want 8", bytes_seen - base);
      end
   endtask

   task automatic test_digits();
      logic [7:0] vals[3];
      int base;
      vals[0] = 8'h07; vals[1] = 8'h64; vals[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         base = bytes_seen;
         raise_dr(vals[i], 1);
         tick();
         data_ready = 1'b0;
         wait_idle("digits", 200);
         n_vec++;
         if (bytes_seen - base != 8) begin
            n_miss++;
            $display("FAIL digits_count: value %h got %0d bytes want 8", vals[i], bytes_seen - base);
         end
      end
   endtask

   task automatic test_level_hold();
      int base;
      base = bytes_seen;
      raise_dr(8'h99, 1);
      repeat (1000) tick();
      n_vec += 2;
      if (bytes_seen - base != 8) begin
         n_miss++;
         $display("FAIL level_hold_count: got %0d bytes want 8", bytes_seen - base);
      end
      if (busy !== 1'b0) begin
         n_miss++;
         $display("FAIL level_hold_busy: got %b want 0", busy);
      end
      data_ready = 1'b0;
      tick();
   endtask

   task automatic test_during_init();
      int base;
      reset = 1'b0;
      tick();
      sb.delete();
      base = bytes_seen;
      reset = 1'b1;
      push_init();
      wait_bytes("init_rise", base + 1, 100);
      raise_dr(8'h2A, 1);
      tick();
      data_ready = 1'b0;
      wait_idle("during_init", 400);
      repeat (100) tick();
      n_vec++;
      if (bytes_seen - base != 12) begin
         n_miss++;
         $display("FAIL during_init_count: got %0d bytes want 12", bytes_seen - base);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = bytes_seen;
      raise_dr(8'h05, 1);
      tick();
      data_ready = 1'b0;
      wait_bytes("b2b_first", base + 2, 100);
      raise_dr(8'h11, 0);
      tick();
      data_ready = 1'b0;
      tick();
      raise_dr(8'hDE, 1);
      tick();
      data_ready = 1'b0;
      wait_idle("back_to_back", 400);
      repeat (100) tick();
      n_vec++;
      if (bytes_seen - base != 16) begin
         n_miss++;
         $display("FAIL back_to_back_count: got %0d bytes want 16", bytes_seen - base);
      end
   endtask

   task automatic test_reset_mid_write();
      int base, n;
      base = bytes_seen;
      raise_dr(8'h80, 1);
      tick();
      data_ready = 1'b0;
      wait_bytes("mid_write", base + 3, 100);
      raise_dr(8'hC8, 0);
      tick();
      data_ready = 1'b0;
      n = 0;
      while (lcd_e !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      #2;
      reset = 1'b0;
      #1;
      n_vec += 4;
      if (lcd_e !== 1'b0)     begin n_miss++; $display("FAIL async_e: got %b want 0", lcd_e); end
      if (busy !== 1'b1)      begin n_miss++; $display("FAIL async_busy: got %b want 1", busy); end
      if (lcd_data !== 8'h00) begin n_miss++; $display("FAIL async_data: got %h want 00", lcd_data); end
      if (lcd_rs !== 1'b0)    begin n_miss++; $display("FAIL async_rs: got %b want 0", lcd_rs); end
      sb.delete();
      repeat (2) tick();
      base = bytes_seen;
      reset = 1'b1;
      push_init();
      wait_idle("reinit", 300);
      repeat (100) tick();
      n_vec += 2;
      if (bytes_seen - base != 4) begin
         n_miss++;
         $display("FAIL reinit_count: got %0d bytes want 4", bytes_seen - base);
      end
      if (busy !== 1'b0) begin
         n_miss++;
         $display("FAIL reinit_busy: got %b want 0", busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running, want finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_ff();
      test_digits();
      test_level_hold();
      test_during_init();
      test_back_to_back();
      test_reset_mid_write();
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL leftover_bytes: got %0d want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
